// File: rtl/fft_input_loader.sv
// fft_input_loader: streams one frame of N = 8 << cfg samples into the FFT
// buffer, then starts the core and waits for it. Optional: FFT_LOADER_BITREV_EN.
module fft_input_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        pnt_cfg_reg,
    input  logic              load_en,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              fft_start,
    input  logic              fft_done,
    output logic              busy,
    output logic [10:0]       sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cfg_lat;
    logic [10:0] last_idx;
    logic        accept;
    logic        last_acc;
    logic        frame_go;
    logic [9:0]  addr_nat;
    logic [9:0]  addr_sel;

`ifdef FFT_LOADER_BITREV_EN
    logic [9:0]  rev_full;
    logic [9:0]  addr_rev;

    // Reverse all 10 bits, then shift down so only the low log2N bits
    // of the count contribute: bits land at [log2N-1:0].
    always_comb begin
        rev_full = '0;
        for (int i = 0; i < 10; i++) begin
            rev_full[i] = addr_nat[9-i];
        end
        addr_rev = rev_full >> (3'd7 - cfg_lat);
    end

    assign addr_sel = addr_rev;
`else
    assign addr_sel = addr_nat;
`endif

    assign addr_nat = sample_cnt[9:0];
    assign last_idx = (11'd8 << cfg_lat) - 11'd1;
    assign frame_go = (state_q == S_IDLE) && load_en && !abort;
    assign busy     = (state_q != S_IDLE);

    // Handshake qualifier; an aborted cycle never takes a sample.
    always_comb begin
        accept   = in_valid && in_ready && (state_q == S_LOAD) && !abort;
        last_acc = accept && (sample_cnt == last_idx);
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (load_en) state_d = S_LOAD;
            S_LOAD:  if (last_acc) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (fft_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // State register and registered ready/start strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b0;
            fft_start <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == S_LOAD);
            fft_start <= (state_q == S_START) && !abort;
        end
    end

    // Point configuration is frozen for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_lat <= '0;
        end else if (frame_go) begin
            cfg_lat <= pnt_cfg_reg;
        end
    end

    // Accepted-sample counter; also the source of the write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (abort || frame_go) begin
            sample_cnt <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 11'd1;
        end
    end

    // Buffer write port, one cycle behind acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wen   <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_wen <= accept;
            if (accept) begin
                mem_waddr <= ADDR_W'(addr_sel);
                mem_wdata <= in_data;
            end
        end
    end

endmodule
